// File: rtl/qtable_update_param.sv
// Q-table update engine: neighbour and cluster-head tables held in registers,
// updated by a sequential search/write FSM, with a combinational read port
// for the routing logic.
module qtable_update_param #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_NB     = 32,
  parameter int MAX_CH     = 8,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fClusterID,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [2:0]            fPacketType,
  input  logic [IDX_W-1:0]      rd_index,
  output logic [WORD_WIDTH-1:0] rd_id,
  output logic [WORD_WIDTH-1:0] rd_cluster,
  output logic [WORD_WIDTH-1:0] rd_energy,
  output logic [WORD_WIDTH-1:0] rd_qvalue,
  output logic [IDX_W-1:0]      neighborCount,
  output logic [IDX_W-1:0]      knownCHCount,
  output logic                  busy,
  output logic                  done,
  output logic                  nb_drop,
  output logic                  ch_drop
);

  // Array address widths; the counters are one bit wider so they can hold
  // the "table full" value itself.
  localparam int NB_AW = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;
  localparam int CH_AW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam logic [IDX_W-1:0] NB_FULL = IDX_W'(MAX_NB);
  localparam logic [IDX_W-1:0] CH_FULL = IDX_W'(MAX_CH);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
  localparam logic [2:0] PKT_HELLO = 3'd1;
  localparam logic [2:0] PKT_CH    = 3'd2;

  typedef enum logic [2:0] {
    IDLE, NB_SEARCH, NB_WR, CH_SEARCH, CH_WR, DONE
  } stateT;

  stateT state, stateNext;

  logic [WORD_WIDTH-1:0] nbId      [MAX_NB];
  logic [WORD_WIDTH-1:0] nbCluster [MAX_NB];
  logic [WORD_WIDTH-1:0] nbEnergy  [MAX_NB];
  logic [WORD_WIDTH-1:0] nbQ       [MAX_NB];
  logic [WORD_WIDTH-1:0] chId      [MAX_CH];
  logic [IDX_W-1:0]      nbCount, chCount;

  logic [WORD_WIDTH-1:0] capId, capCluster, capEnergy, capQ;
  logic [2:0]            capType;
  logic [IDX_W-1:0]      idx, minIdx, target;
  logic                  hit, nbDropPending, chDropPending;

  logic [NB_AW-1:0] nbIdxT, nbMinT, nbTgtT, nbCntT, rdT;
  logic [CH_AW-1:0] chIdxT, chCntT;
  logic             typeValid, nbAtEnd, nbMatch, chAtEnd, chMatch;

  assign nbIdxT = idx[NB_AW-1:0];
  assign nbMinT = minIdx[NB_AW-1:0];
  assign nbTgtT = target[NB_AW-1:0];
  assign nbCntT = nbCount[NB_AW-1:0];
  assign chIdxT = idx[CH_AW-1:0];
  assign chCntT = chCount[CH_AW-1:0];
  assign rdT    = rd_index[NB_AW-1:0];

  assign typeValid = (capType == PKT_HELLO) || (capType == PKT_CH);
  assign nbAtEnd   = (idx == nbCount);
  assign nbMatch   = !nbAtEnd && (nbId[nbIdxT] == capId);
  assign chAtEnd   = (idx == chCount);
  assign chMatch   = !chAtEnd && (chId[chIdxT] == capCluster);

  // State register; reset drops straight back to IDLE, abandoning any search.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state selection: searches walk one entry per cycle until a match or
  // the end of the valid region is reached.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (en) stateNext = NB_SEARCH;
      NB_SEARCH: begin
        if (!typeValid)                stateNext = DONE;
        else if (nbAtEnd || nbMatch)   stateNext = NB_WR;
      end
      NB_WR:     stateNext = (capType == PKT_HELLO) ? DONE : CH_SEARCH;
      CH_SEARCH: begin
        if (chAtEnd)      stateNext = CH_WR;
        else if (chMatch) stateNext = DONE;
      end
      CH_WR:     stateNext = DONE;
      DONE:      stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Datapath: packet capture, search pointers and all table writes. Tables
  // only change in the *_WR states so an aborted packet leaves nothing behind.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < MAX_NB; i++) begin
        nbId[i]      <= '0;
        nbCluster[i] <= '0;
        nbEnergy[i]  <= '0;
        nbQ[i]       <= '0;
      end
      for (int i = 0; i < MAX_CH; i++) chId[i] <= '0;
      nbCount       <= '0;
      chCount       <= '0;
      capId         <= '0;
      capCluster    <= '0;
      capEnergy     <= '0;
      capQ          <= '0;
      capType       <= '0;
      idx           <= '0;
      minIdx        <= '0;
      target        <= '0;
      hit           <= 1'b0;
      nbDropPending <= 1'b0;
      chDropPending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            capId      <= fSourceID;
            capCluster <= fClusterID;
            capEnergy  <= fEnergyLeft;
            capQ       <= fQValue;
            capType    <= fPacketType;
            idx        <= '0;
            minIdx     <= '0;
            hit        <= 1'b0;
          end
        end
        NB_SEARCH: begin
          if (typeValid && !nbAtEnd) begin
            if (nbMatch) begin
              hit    <= 1'b1;
              target <= idx;
            end else begin
              if (nbQ[nbIdxT] < nbQ[nbMinT]) minIdx <= idx;
              idx <= idx + ONE;
            end
          end
        end
        NB_WR: begin
          if (hit) begin
            nbCluster[nbTgtT] <= capCluster;
            nbEnergy[nbTgtT]  <= capEnergy;
            nbQ[nbTgtT]       <= capQ;
          end else if (nbCount < NB_FULL) begin
            nbId[nbCntT]      <= capId;
            nbCluster[nbCntT] <= capCluster;
            nbEnergy[nbCntT]  <= capEnergy;
            nbQ[nbCntT]       <= capQ;
            nbCount           <= nbCount + ONE;
          end else if (capQ > nbQ[nbMinT]) begin
            nbId[nbMinT]      <= capId;
            nbCluster[nbMinT] <= capCluster;
            nbEnergy[nbMinT]  <= capEnergy;
            nbQ[nbMinT]       <= capQ;
          end else begin
            nbDropPending <= 1'b1;
          end
          idx <= '0;
        end
        CH_SEARCH: begin
          if (!chAtEnd && !chMatch) idx <= idx + ONE;
        end
        CH_WR: begin
          if (chCount < CH_FULL) begin
            chId[chCntT] <= capCluster;
            chCount      <= chCount + ONE;
          end else begin
            chDropPending <= 1'b1;
          end
        end
        DONE: begin
          nbDropPending <= 1'b0;
          chDropPending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Read port returns zeros outside the valid region of the neighbour table.
  always_comb begin
    rd_id      = '0;
    rd_cluster = '0;
    rd_energy  = '0;
    rd_qvalue  = '0;
    if (rd_index < nbCount) begin
      rd_id      = nbId[rdT];
      rd_cluster = nbCluster[rdT];
      rd_energy  = nbEnergy[rdT];
      rd_qvalue  = nbQ[rdT];
    end
  end

  assign neighborCount = nbCount;
  assign knownCHCount  = chCount;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign nb_drop       = (state == DONE) && nbDropPending;
  assign ch_drop       = (state == DONE) && chDropPending;

endmodule

// File: tb/tb_qtable_update_param.sv
// Bench for qtable_update_param: a table of packets with hand-derived
// latency/flag/count expectations, scoreboarded per packet, plus sequences
// for reset, mid-operation reset and en held high.
module tb_qtable_update_param;

  localparam int WW = 16;
  localparam int NB = 8;
  localparam int CH = 4;
  localparam int IW = 4;

  logic          clk, nrst, en;
  logic [WW-1:0] fSourceID, fClusterID, fEnergyLeft, fQValue;
  logic [2:0]    fPacketType;
  logic [IW-1:0] rd_index;
  logic [WW-1:0] rd_id, rd_cluster, rd_energy, rd_qvalue;
  logic [IW-1:0] neighborCount, knownCHCount;
  logic          busy, done, nb_drop, ch_drop;

  qtable_update_param #(.WORD_WIDTH(WW), .MAX_NB(NB), .MAX_CH(CH), .IDX_W(IW)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .fSourceID(fSourceID), .fClusterID(fClusterID), .fEnergyLeft(fEnergyLeft),
    .fQValue(fQValue), .fPacketType(fPacketType), .rd_index(rd_index),
    .rd_id(rd_id), .rd_cluster(rd_cluster), .rd_energy(rd_energy),
    .rd_qvalue(rd_qvalue), .neighborCount(neighborCount),
    .knownCHCount(knownCHCount), .busy(busy), .done(done),
    .nb_drop(nb_drop), .ch_drop(ch_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    pType;
    logic [WW-1:0] id, cl, en, q;
    int            lat;
    logic          nbDrop, chDrop;
    int            nbCnt, chCnt;
  } vecT;

  typedef struct {
    int   lat;
    logic nbDrop, chDrop;
    int   nbCnt, chCnt;
  } expT;

  vecT vecs[17];
  expT sb[$];
  int  vecApplied = 0;
  int  compares   = 0;
  int  miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkEntry(input int i, input int id, input int cl,
                            input int enr, input int q);
    rd_index = IW'(i);
    #1;
    checkOutput($sformatf("rd_id[%0d]", i), 32'(rd_id), id);
    checkOutput($sformatf("rd_cluster[%0d]", i), 32'(rd_cluster), cl);
    checkOutput($sformatf("rd_energy[%0d]", i), 32'(rd_energy), enr);
    checkOutput($sformatf("rd_qvalue[%0d]", i), 32'(rd_qvalue), q);
  endtask

  // Drive one packet, push its expectation, then wait (bounded) for done
  // and compare against the popped expectation.
  task automatic applyStimulus(input vecT v);
    expT e;
    expT got;
    int  cyc;
    @(negedge clk);
    fSourceID   = v.id;
    fClusterID  = v.cl;
    fEnergyLeft = v.en;
    fQValue     = v.q;
    fPacketType = v.pType;
    en          = 1'b1;
    e.lat = v.lat; e.nbDrop = v.nbDrop; e.chDrop = v.chDrop;
    e.nbCnt = v.nbCnt; e.chCnt = v.chCnt;
    sb.push_back(e);
    vecApplied++;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      en = 1'b0;
      cyc++;
      if (done) break;
    end
    got = sb.pop_front();
    if (!done) begin
      checkOutput("done timeout", 32'(cyc), 32'(got.lat));
    end else begin
      checkOutput("latency", 32'(cyc), 32'(got.lat));
      checkOutput("nb_drop", 32'(nb_drop), 32'(got.nbDrop));
      checkOutput("ch_drop", 32'(ch_drop), 32'(got.chDrop));
      checkOutput("neighborCount", 32'(neighborCount), 32'(got.nbCnt));
      checkOutput("knownCHCount", 32'(knownCHCount), 32'(got.chCnt));
    end
    @(posedge clk);
    #1;
    checkOutput("idle after done", 32'(busy), 32'd0);
  endtask

  initial begin
    int doneCount;
    int firstLat;
    nrst = 1'b0; en = 1'b0; rd_index = '0;
    fSourceID = '0; fClusterID = '0; fEnergyLeft = '0; fQValue = '0;
    fPacketType = '0;

    //            type  id  cl   en   q   lat nbD chD nbC chC
    vecs[0]  = '{3'd1,  5,  2, 100, 40,  3, 0, 0, 1, 0};
    vecs[1]  = '{3'd1,  9,  3,  90, 30,  4, 0, 0, 2, 0};
    vecs[2]  = '{3'd1, 12,  4,  80, 20,  5, 0, 0, 3, 0};
    vecs[3]  = '{3'd1,  9,  3,  91, 77,  4, 0, 0, 3, 0};
    vecs[4]  = '{3'd2,  7,  7,  50, 60,  8, 0, 0, 4, 1};
    vecs[5]  = '{3'd2,  7,  7,  50, 60,  7, 0, 0, 4, 1};
    vecs[6]  = '{3'd5, 44, 44,  44, 44,  2, 0, 0, 4, 1};
    vecs[7]  = '{3'd2, 20, 21, 120,  5, 10, 0, 0, 5, 2};
    vecs[8]  = '{3'd2, 21, 22, 121,  6, 12, 0, 0, 6, 3};
    vecs[9]  = '{3'd2, 22, 23, 122,  7, 14, 0, 0, 7, 4};
    vecs[10] = '{3'd2, 23, 24, 123,  8, 16, 0, 1, 8, 4};
    vecs[11] = '{3'd1, 30,  1, 130, 50, 11, 0, 0, 8, 4};
    vecs[12] = '{3'd1, 31,  1, 131,  6, 11, 1, 0, 8, 4};
    vecs[13] = '{3'd1, 32,  1, 132,  7, 11, 0, 0, 8, 4};
    vecs[14] = '{3'd1, 33,  1, 133,  8, 11, 0, 0, 8, 4};
    vecs[15] = '{3'd1,  5,  2, 100,  1,  3, 0, 0, 8, 4};
    vecs[16] = '{3'd2,  5,  7, 100,  1,  4, 0, 0, 8, 4};

    // Reset state while nrst is held low.
    #12;
    vecApplied++;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset neighborCount", 32'(neighborCount), 32'd0);
    checkOutput("reset knownCHCount", 32'(knownCHCount), 32'd0);
    checkEntry(0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      if (i == 0)  checkEntry(0, 5, 2, 100, 40);
      if (i == 3)  checkEntry(1, 9, 3, 91, 77);
      if (i == 6)  checkEntry(4, 0, 0, 0, 0);
      if (i == 11) checkEntry(4, 30, 1, 130, 50);
      if (i == 12) checkEntry(5, 21, 22, 121, 6);
      if (i == 14) begin
        checkEntry(5, 33, 1, 133, 8);
        checkEntry(6, 22, 23, 122, 7);
      end
    end

    // Reset asserted in the middle of a neighbour search.
    vecApplied++;
    @(negedge clk);
    fSourceID = 40; fClusterID = 1; fEnergyLeft = 140; fQValue = 90;
    fPacketType = 3'd1; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    checkOutput("busy mid search", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort neighborCount", 32'(neighborCount), 32'd0);
    checkOutput("abort knownCHCount", 32'(knownCHCount), 32'd0);
    checkEntry(0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;

    // en held high throughout a packet: exactly one capture, one done.
    vecApplied++;
    doneCount = 0;
    firstLat  = 0;
    @(negedge clk);
    fSourceID = 50; fClusterID = 3; fEnergyLeft = 150; fQValue = 12;
    fPacketType = 3'd1; en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        if (firstLat == 0) firstLat = c;
        en = 1'b0;
      end
    end
    en = 1'b0;
    checkOutput("held en done count", 32'(doneCount), 32'd1);
    checkOutput("held en latency", 32'(firstLat), 32'd3);
    checkOutput("held en neighborCount", 32'(neighborCount), 32'd1);
    checkEntry(0, 50, 3, 150, 12);
    checkEntry(1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecApplied, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
